// File: rtl/grf_scoreboard.sv
// Per-register pending-write scoreboard for GRF RAW hazard detection.
// Stall is combinational (zero latency); pending/inflight/error flags are registered.
module grf_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_we,
    input  logic [4:0]  issue_a3,
    input  logic        wb_we,
    input  logic [4:0]  wb_a3,
    input  logic        flush,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic        rs_use,
    input  logic        rt_use,
    output logic        stall,
    output logic [31:0] pending,
    output logic [7:0]  inflight,
    output logic        ovf_err,
    output logic        unf_err
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [31:0][CNT_W-1:0] cnt_q;
    logic [31:0][CNT_W-1:0] cnt_d;
    logic [31:0]            pending_d;
    logic [7:0]             inflight_d;
    logic                   ovf_d;
    logic                   unf_d;
    logic                   inc;
    logic                   dec;
    logic                   same_reg;

    assign inc      = issue_we && (issue_a3 != 5'd0);
    assign dec      = wb_we && (wb_a3 != 5'd0);
    assign same_reg = inc && dec && (issue_a3 == wb_a3);

    // Write-through: a register whose last pending write retires this cycle no longer blocks.
    function automatic logic hz(input logic [4:0] a, input logic u,
                                input logic [CNT_W-1:0] c, input logic dec_hit);
        hz = u && (a != 5'd0) && (c != '0) && !(dec_hit && (c == ONE));
    endfunction

    always_comb begin
        stall = hz(rs_addr, rs_use, cnt_q[rs_addr], dec && (wb_a3 == rs_addr))
              | hz(rt_addr, rt_use, cnt_q[rt_addr], dec && (wb_a3 == rt_addr));
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_err;
        unf_d = unf_err;
        if (flush) begin
            cnt_d = '0;
        end else if (!same_reg) begin
            if (inc) begin
                if (cnt_q[issue_a3] == MAX) ovf_d = 1'b1;
                else                        cnt_d[issue_a3] = cnt_q[issue_a3] + ONE;
            end
            if (dec) begin
                if (cnt_q[wb_a3] == '0) unf_d = 1'b1;
                else                    cnt_d[wb_a3] = cnt_q[wb_a3] - ONE;
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        pending_d  = '0;
        inflight_d = '0;
        for (int i = 1; i < 32; i++) begin
            pending_d[i] = (cnt_d[i] != '0);
            inflight_d   = inflight_d + 8'(cnt_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            pending  <= '0;
            inflight <= '0;
            ovf_err  <= 1'b0;
            unf_err  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pending  <= pending_d;
            inflight <= inflight_d;
            ovf_err  <= ovf_d;
            unf_err  <= unf_d;
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench for grf_scoreboard: directed scenarios plus randomized traffic vs. a count-array model.
module tb_grf_scoreboard;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset, issue_we, wb_we, flush, rs_use, rt_use;
    logic [4:0]  issue_a3, wb_a3, rs_addr, rt_addr;
    logic        stall, ovf_err, unf_err;
    logic [31:0] pending;
    logic [7:0]  inflight;

    int tests_run    = 0;
    int tests_failed = 0;

    int m_cnt [32];
    bit m_ovf, m_unf;

    always #5 clk = ~clk;

    grf_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .issue_we(issue_we), .issue_a3(issue_a3),
        .wb_we(wb_we), .wb_a3(wb_a3), .flush(flush),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_use(rs_use), .rt_use(rt_use),
        .stall(stall), .pending(pending), .inflight(inflight),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    // Reference model: a plain integer count per register, updated from the rules at each edge.
    function automatic void model_step();
        bit inc, dec;
        if (reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        if (flush) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            return;
        end
        inc = issue_we && issue_a3 != 0;
        dec = wb_we && wb_a3 != 0;
        if (inc && dec && issue_a3 == wb_a3) return;
        if (inc) begin
            if (m_cnt[issue_a3] == MAXC) m_ovf = 1;
            else m_cnt[issue_a3] = m_cnt[issue_a3] + 1;
        end
        if (dec) begin
            if (m_cnt[wb_a3] == 0) m_unf = 1;
            else m_cnt[wb_a3] = m_cnt[wb_a3] - 1;
        end
    endfunction

    function automatic bit model_hz(input logic [4:0] a, input logic u);
        int e;
        e = m_cnt[a];
        if (wb_we && wb_a3 == a && e > 0) e = e - 1;
        return u && a != 0 && e > 0;
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        for (int i = 1; i < 32; i++) p[i] = (m_cnt[i] != 0);
        return p;
    endfunction

    function automatic int model_inflight();
        int s = 0;
        for (int i = 1; i < 32; i++) s += m_cnt[i];
        return s;
    endfunction

    task automatic clear_inputs();
        reset = 0; issue_we = 0; issue_a3 = 0; wb_we = 0; wb_a3 = 0; flush = 0;
        rs_addr = 0; rt_addr = 0; rs_use = 0; rt_use = 0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then release inputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        reset = 1;
        issue_we = 1; issue_a3 = 5'd4;
        tick();
        tests_run++;
        if (pending !== 32'h0 || inflight !== 8'd0 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: pending=%h inflight=%0d ovf=%b unf=%b, want all zero",
                     pending, inflight, ovf_err, unf_err);
        end
        rs_addr = 5'd4; rs_use = 1; rt_addr = 5'd4; rt_use = 1;
        #2;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stall: stall=%b want 0", stall);
        end
        tick();
    endtask

    task automatic test_issue_read();
        issue_we = 1; issue_a3 = 5'd5;
        tick();
        rs_addr = 5'd5; rs_use = 1;
        #2;
        tests_run++;
        if (stall !== 1'b1 || pending !== 32'h0000_0020 || inflight !== 8'd1) begin
            tests_failed++;
            $display("FAIL issue_read_c1: stall=%b pending=%h inflight=%0d want 1/00000020/1",
                     stall, pending, inflight);
        end
        tick();
        rs_addr = 5'd5; rs_use = 1;
        tick();
        rs_addr = 5'd5; rs_use = 1; wb_we = 1; wb_a3 = 5'd5;
        #2;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_through: stall=%b want 0", stall);
        end
        tick();
        tests_run++;
        if (pending !== 32'h0 || inflight !== 8'd0) begin
            tests_failed++;
            $display("FAIL retire: pending=%h inflight=%0d want 0/0", pending, inflight);
        end
    endtask

    task automatic test_zero_reg();
        issue_we = 1; issue_a3 = 5'd0; rt_addr = 5'd0; rt_use = 1;
        #2;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_stall: stall=%b want 0", stall);
        end
        tick();
        tests_run++;
        if (pending !== 32'h0 || inflight !== 8'd0) begin
            tests_failed++;
            $display("FAIL zero_issue: pending=%h inflight=%0d want 0/0", pending, inflight);
        end
        wb_we = 1; wb_a3 = 5'd0;
        tick();
        tests_run++;
        if (unf_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_wb: unf_err=%b want 0", unf_err);
        end
    endtask

    task automatic test_simultaneous();
        issue_we = 1; issue_a3 = 5'd7;
        tick();
        issue_we = 1; issue_a3 = 5'd7; wb_we = 1; wb_a3 = 5'd7; rs_addr = 5'd7; rs_use = 1;
        #2;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_reg_stall: stall=%b want 0", stall);
        end
        tick();
        rs_addr = 5'd7; rs_use = 1;
        #2;
        tests_run++;
        if (stall !== 1'b1 || pending !== 32'h0000_0080 || inflight !== 8'd1) begin
            tests_failed++;
            $display("FAIL same_reg_next: stall=%b pending=%h inflight=%0d want 1/00000080/1",
                     stall, pending, inflight);
        end
        tick();
        issue_we = 1; issue_a3 = 5'd8; wb_we = 1; wb_a3 = 5'd7;
        tick();
        tests_run++;
        if (pending !== 32'h0000_0100 || inflight !== 8'd1) begin
            tests_failed++;
            $display("FAIL diff_reg: pending=%h inflight=%0d want 00000100/1", pending, inflight);
        end
        wb_we = 1; wb_a3 = 5'd8;
        tick();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 4; k++) begin
            issue_we = 1; issue_a3 = 5'd9;
            tick();
        end
        tests_run++;
        if (inflight !== 8'd3 || ovf_err !== 1'b1 || pending !== 32'h0000_0200 || unf_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL saturate: inflight=%0d ovf=%b unf=%b pending=%h want 3/1/0/00000200",
                     inflight, ovf_err, unf_err, pending);
        end
        wb_we = 1; wb_a3 = 5'd1;
        tick();
        tests_run++;
        if (unf_err !== 1'b1 || inflight !== 8'd3) begin
            tests_failed++;
            $display("FAIL underflow: unf=%b inflight=%0d want 1/3", unf_err, inflight);
        end
        tick();
        tick();
        tests_run++;
        if (ovf_err !== 1'b1 || unf_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL sticky: ovf=%b unf=%b want 1/1", ovf_err, unf_err);
        end
    endtask

    task automatic test_flush();
        issue_we = 1; issue_a3 = 5'd3; tick();
        issue_we = 1; issue_a3 = 5'd3; tick();
        issue_we = 1; issue_a3 = 5'd4; tick();
        flush = 1; issue_we = 1; issue_a3 = 5'd6;
        tick();
        tests_run++;
        if (pending !== 32'h0 || inflight !== 8'd0 || ovf_err !== 1'b1 || unf_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush: pending=%h inflight=%0d ovf=%b unf=%b want 0/0/1/1",
                     pending, inflight, ovf_err, unf_err);
        end
    endtask

    task automatic test_reset_mid();
        issue_we = 1; issue_a3 = 5'd2; tick();
        for (int k = 0; k < 4; k++) begin
            issue_we = 1; issue_a3 = 5'd9; tick();
        end
        reset = 1; issue_we = 1; issue_a3 = 5'd2;
        tick();
        rs_addr = 5'd2; rs_use = 1;
        #2;
        tests_run++;
        if (stall !== 1'b0 || pending !== 32'h0 || inflight !== 8'd0 ||
            ovf_err !== 1'b0 || unf_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: stall=%b pending=%h inflight=%0d ovf=%b unf=%b want all 0",
                     stall, pending, inflight, ovf_err, unf_err);
        end
        tick();
    endtask

    task automatic test_random();
        int prints = 0;
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 59) == 0);
            issue_we = ($urandom_range(0, 2) != 0);
            issue_a3 = 5'($urandom_range(0, 6));
            wb_we    = ($urandom_range(0, 2) != 0);
            wb_a3    = 5'($urandom_range(0, 6));
            rs_addr  = 5'($urandom_range(0, 6));
            rt_addr  = 5'($urandom_range(0, 31));
            rs_use   = 1'($urandom_range(0, 1));
            rt_use   = 1'($urandom_range(0, 1));
            #2;
            tests_run++;
            if (stall !== (model_hz(rs_addr, rs_use) | model_hz(rt_addr, rt_use))) begin
                tests_failed++;
                if (prints++ < 20)
                    $display("FAIL rand_stall[%0d]: stall=%b want %b", n, stall,
                             model_hz(rs_addr, rs_use) | model_hz(rt_addr, rt_use));
            end
            tick();
            tests_run++;
            if (pending !== model_pending() || inflight !== 8'(model_inflight()) ||
                ovf_err !== m_ovf || unf_err !== m_unf) begin
                tests_failed++;
                if (prints++ < 20)
                    $display("FAIL rand_state[%0d]: pending=%h inflight=%0d ovf=%b unf=%b want %h/%0d/%b/%b",
                             n, pending, inflight, ovf_err, unf_err,
                             model_pending(), model_inflight(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        clear_inputs();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_ovf = 0;
        m_unf = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_issue_read();
        test_zero_reg();
        test_simultaneous();
        test_saturation();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
